ram512_arbiter: RTL and testbench

RAM512_ARBITER -- requirements
Module: ram512_arbiter

---
 rtl/ram512_arbiter_if.sv | 33 +++
 rtl/ram512_arbiter.sv | 130 +++++++++++++
 tb/tb_ram512_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram512_arbiter_if.sv
// ram512_arbiter_if -- bundles the two requester ports, the shared response
// and the RAM-side signals of ram512_arbiter.
//   master : the environment (requesters plus the RAM that returns ram_out)
//   slave  : the arbiter itself
interface ram512_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [8:0]  addr0;
    logic [8:0]  addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [15:0] rdata;
    logic [8:0]  ram_addr;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_in, ram_load
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_in, ram_load
    );
endinterface

// File: rtl/ram512_arbiter.sv
// ram512_arbiter -- two requesters sharing one 512x16 single-port RAM.
// Each access takes an ACCESS cycle (gnt pulse, RAM driven) followed by a
// RESP cycle (rvalid pulse, read data presented); back-to-back accesses run
// at one per two cycles.
// Build option: define RAM512_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins ties); the default build arbitrates round-robin.
module ram512_arbiter (
    input  logic            clk,
    input  logic            rst_n,
    ram512_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        winner;
    logic        lat_we;
    logic [8:0]  lat_addr;
    logic [15:0] lat_wdata;
    logic [15:0] rdata_q;

    logic        any_req;
    logic        tie_pick;
    logic        pick;
    logic        arb_now;

`ifndef RAM512_ARB_FIXED_PRIO_EN
    logic        last_winner;
`endif

    // Decide who would win an arbitration taking place at the coming edge
    always_comb begin
        any_req = bus.req0 | bus.req1;
`ifdef RAM512_ARB_FIXED_PRIO_EN
        tie_pick = 1'b0;
`else
        tie_pick = ~last_winner;
`endif
        if (bus.req0 && bus.req1) begin
            pick = tie_pick;
        end else begin
            pick = bus.req1;
        end
        arb_now = any_req && (state != ACCESS);
    end

    // State register; reset forces IDLE at once so ram_load drops asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: requests are ignored while the RAM is being accessed
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = any_req ? ACCESS : IDLE;
            ACCESS:  next_state = RESP;
            RESP:    next_state = any_req ? ACCESS : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake pulses and RAM write enable decoded from the current state
    always_comb begin
        bus.gnt0     = 1'b0;
        bus.gnt1     = 1'b0;
        bus.rvalid0  = 1'b0;
        bus.rvalid1  = 1'b0;
        bus.ram_load = 1'b0;
        case (state)
            ACCESS: begin
                bus.gnt0     = ~winner;
                bus.gnt1     = winner;
                bus.ram_load = lat_we;
            end
            RESP: begin
                bus.rvalid0 = ~winner;
                bus.rvalid1 = winner;
            end
            default: ;
        endcase
    end

    // Latch the winner's command on arbitration and capture read data after ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 9'd0;
            lat_wdata <= 16'd0;
            rdata_q   <= 16'd0;
        end else begin
            if (arb_now) begin
                winner    <= pick;
                lat_we    <= pick ? bus.we1    : bus.we0;
                lat_addr  <= pick ? bus.addr1  : bus.addr0;
                lat_wdata <= pick ? bus.wdata1 : bus.wdata0;
            end
            if (state == ACCESS) begin
                rdata_q <= bus.ram_out;
            end
        end
    end

`ifndef RAM512_ARB_FIXED_PRIO_EN
    // Remember the last granted requester; reset value 1 lets requester 0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
        end else if (arb_now) begin
            last_winner <= pick;
        end
    end
`endif

    assign bus.rdata    = rdata_q;
    assign bus.ram_addr = lat_addr;
    assign bus.ram_in   = lat_wdata;

endmodule

// File: tb/tb_ram512_arbiter.sv
// tb_ram512_arbiter -- directed bench for ram512_arbiter with a 512x16 RAM
// model, a transaction-level reference model and a per-cycle compare process.
// Honours RAM512_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_ram512_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ram512_arbiter_if bus ();

    ram512_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [15:0] init_word(input int i);
        if (i == 511) return 16'h1234;
        if (i == 7)   return 16'h0777;
        return 16'((i * 37) ^ 16'h5A5A);
    endfunction

    // RAM: combinational read, write sampled at the edge and applied just after it
    logic [15:0] ram [512];
    assign bus.ram_out = ram[bus.ram_addr];

    initial begin
        logic        ld;
        logic [8:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 512; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            ld = bus.ram_load;
            a  = bus.ram_addr;
            d  = bus.ram_in;
            #1;
            if (ld === 1'b1) ram[a] = d;
        end
    end

    // Reference model: an arbitration may happen at any edge with a request,
    // except the edge directly after an arbitration (the access is in flight).
    logic [15:0] mm [512];
    bit          m_in_reset;
    bit          m_arb_prev;
    int          m_last;
    int          m_w;
    bit          m_we;
    logic [8:0]  m_addr;
    logic [15:0] m_wdata;
    bit          e_gnt0, e_gnt1, e_rv0, e_rv1, e_load, e_busy;
    logic [15:0] e_rdata;
    logic [8:0]  e_raddr;
    logic [15:0] e_rin;

    task automatic model_reset();
        m_in_reset = 1'b1;
        m_arb_prev = 1'b0;
        m_last     = 1;
        e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_load = 0; e_busy = 0;
        e_rdata = 16'd0; e_raddr = 9'd0; e_rin = 16'd0;
    endtask

    task automatic model_step();
        int w;
        m_in_reset = 1'b0;
        e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_load = 0;
        if (m_arb_prev) begin
            if (m_w == 0) e_rv0 = 1; else e_rv1 = 1;
            e_rdata = mm[m_addr];
            if (m_we) mm[m_addr] = m_wdata;
            e_busy     = 1;
            m_arb_prev = 1'b0;
        end else if (bus.req0 || bus.req1) begin
            if (bus.req0 && bus.req1) begin
`ifdef RAM512_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = (m_last == 0) ? 1 : 0;
`endif
            end else begin
                w = bus.req0 ? 0 : 1;
            end
            m_w     = w;
            m_last  = w;
            m_we    = (w == 0) ? bus.we0    : bus.we1;
            m_addr  = (w == 0) ? bus.addr0  : bus.addr1;
            m_wdata = (w == 0) ? bus.wdata0 : bus.wdata1;
            if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
            e_load     = m_we;
            e_raddr    = m_addr;
            e_rin      = m_wdata;
            e_busy     = 1;
            m_arb_prev = 1'b1;
        end else begin
            e_busy     = 0;
            m_arb_prev = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mm[i] = init_word(i);
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check_output("cyc_gnt0",     32'(bus.gnt0),     32'(e_gnt0));
            check_output("cyc_gnt1",     32'(bus.gnt1),     32'(e_gnt1));
            check_output("cyc_rvalid0",  32'(bus.rvalid0),  32'(e_rv0));
            check_output("cyc_rvalid1",  32'(bus.rvalid1),  32'(e_rv1));
            check_output("cyc_ram_load", 32'(bus.ram_load), 32'(e_load));
            if (m_in_reset) begin
                check_output("rst_rdata",    32'(bus.rdata),    32'd0);
                check_output("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
                check_output("rst_ram_in",   32'(bus.ram_in),   32'd0);
            end else begin
                if (e_busy) begin
                    check_output("cyc_ram_addr", 32'(bus.ram_addr), 32'(e_raddr));
                    check_output("cyc_ram_in",   32'(bus.ram_in),   32'(e_rin));
                end
                if (e_rv0 || e_rv1) begin
                    check_output("cyc_rdata", 32'(bus.rdata), 32'(e_rdata));
                end
            end
        end
    end

    task automatic apply_stimulus(input int port, input bit req, input bit we,
                                  input logic [8:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    function automatic bit pulse_seen(input int port, input bit want_rvalid);
        if (want_rvalid) return (port == 0) ? bus.rvalid0 : bus.rvalid1;
        return (port == 0) ? bus.gnt0 : bus.gnt1;
    endfunction

    task automatic wait_pulse(input int port, input bit want_rvalid, output int cycles);
        cycles = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (pulse_seen(port, want_rvalid)) begin
                cycles = c;
                break;
            end
        end
    endtask

    // One complete access from a single requester; latencies count from the sampling edge
    task automatic do_access(input int port, input bit we, input logic [8:0] addr,
                             input logic [15:0] wdata, output int gnt_lat,
                             output int rv_lat, output logic [15:0] rd,
                             output logic load_at_gnt);
        int g;
        int r;
        apply_stimulus(port, 1'b1, we, addr, wdata);
        wait_pulse(port, 1'b0, g);
        gnt_lat     = g;
        load_at_gnt = bus.ram_load;
        apply_stimulus(port, 1'b0, we, addr, wdata);
        wait_pulse(port, 1'b1, r);
        rv_lat = (g < 0 || r < 0) ? -1 : g + r;
        rd     = bus.rdata;
    endtask

    initial begin
        int          seq [$];
        int          gcyc [$];
        int          gl;
        int          rl;
        int          c;
        logic [15:0] rd;
        logic        ld;
        int          exp_seq [4];

        apply_stimulus(0, 1'b0, 1'b0, 9'd0, 16'd0);
        apply_stimulus(1, 1'b0, 1'b0, 9'd0, 16'd0);
        repeat (2) @(negedge clk);
        check_output("reset_gnt0",     32'(bus.gnt0),     32'd0);
        check_output("reset_rvalid1",  32'(bus.rvalid1),  32'd0);
        check_output("reset_ram_load", 32'(bus.ram_load), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters held continuously: requester 0 writes, requester 1 reads
        apply_stimulus(0, 1'b1, 1'b1, 9'd20, 16'hC0DE);
        apply_stimulus(1, 1'b1, 1'b0, 9'd21, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.gnt0) begin
                seq.push_back(0); gcyc.push_back(k);
                check_output("both_load_w0", 32'(bus.ram_load), 32'd1);
            end
            if (bus.gnt1) begin
                seq.push_back(1); gcyc.push_back(k);
                check_output("both_load_w1", 32'(bus.ram_load), 32'd0);
            end
        end
        apply_stimulus(0, 1'b0, 1'b0, 9'd0, 16'd0);
        apply_stimulus(1, 1'b0, 1'b0, 9'd0, 16'd0);
`ifdef RAM512_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        check_output("both_grant_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output("both_winner", (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF,
                         32'(exp_seq[i]));
            check_output("both_gnt_cycle", (i < gcyc.size()) ? 32'(gcyc[i]) : 32'hFFFF_FFFF,
                         32'(2 * i + 1));
        end
        repeat (2) @(negedge clk);

        // Write then read on requester 0
        do_access(0, 1'b1, 9'd5, 16'hBEEF, gl, rl, rd, ld);
        check_output("wr5_gnt_latency",    32'(gl), 32'd1);
        check_output("wr5_rvalid_latency", 32'(rl), 32'd2);
        check_output("wr5_load_at_gnt",    32'(ld), 32'd1);
        check_output("wr5_old_data",       32'(rd), 32'(init_word(5)));
        do_access(0, 1'b0, 9'd5, 16'h0000, gl, rl, rd, ld);
        check_output("rd5_data",        32'(rd), 32'hBEEF);
        check_output("rd5_load_at_gnt", 32'(ld), 32'd0);

        // Read-before-write at the top address
        do_access(0, 1'b1, 9'd511, 16'hABCD, gl, rl, rd, ld);
        check_output("wr511_old_data", 32'(rd), 32'h1234);
        do_access(0, 1'b0, 9'd511, 16'h0000, gl, rl, rd, ld);
        check_output("rd511_new_data", 32'(rd), 32'hABCD);
        do_access(1, 1'b0, 9'd5, 16'h0000, gl, rl, rd, ld);
        check_output("rd5_port1_data",  32'(rd), 32'hBEEF);
        check_output("rd5_port1_gnt",   32'(gl), 32'd1);
        repeat (2) @(negedge clk);

        // req1 alone, then both requesting in its RESP cycle: requester 0 wins next
        apply_stimulus(1, 1'b1, 1'b0, 9'd30, 16'h0000);
        wait_pulse(1, 1'b0, c);
        check_output("solo1_gnt_latency", 32'(c), 32'd1);
        apply_stimulus(1, 1'b0, 1'b0, 9'd30, 16'h0000);
        @(negedge clk);
        check_output("solo1_rvalid", 32'(bus.rvalid1), 32'd1);
        apply_stimulus(0, 1'b1, 1'b0, 9'd5, 16'h0000);
        apply_stimulus(1, 1'b1, 1'b0, 9'd511, 16'h0000);
        @(negedge clk);
        check_output("tie_gnt0", 32'(bus.gnt0), 32'd1);
        check_output("tie_gnt1", 32'(bus.gnt1), 32'd0);
        apply_stimulus(0, 1'b0, 1'b0, 9'd5, 16'h0000);
        @(negedge clk);
        check_output("tie_rdata0", 32'(bus.rdata), 32'hBEEF);
        @(negedge clk);
        check_output("tie_then_gnt1", 32'(bus.gnt1), 32'd1);
        apply_stimulus(1, 1'b0, 1'b0, 9'd511, 16'h0000);
        @(negedge clk);
        check_output("tie_rdata1", 32'(bus.rdata), 32'hABCD);
        repeat (2) @(negedge clk);

        // Reset pulsed in the middle of a write's ACCESS cycle
        apply_stimulus(0, 1'b1, 1'b1, 9'd7, 16'h00FF);
        wait_pulse(0, 1'b0, c);
        check_output("rstacc_gnt_latency", 32'(c), 32'd1);
        check_output("rstacc_load_before", 32'(bus.ram_load), 32'd1);
        #1;
        rst_n = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, 9'd0, 16'h0000);
        #1;
        check_output("rstacc_load_async", 32'(bus.ram_load), 32'd0);
        check_output("rstacc_gnt0",       32'(bus.gnt0),     32'd0);
        check_output("rstacc_rdata",      32'(bus.rdata),    32'd0);
        check_output("rstacc_ram_addr",   32'(bus.ram_addr), 32'd0);
        check_output("rstacc_ram_in",     32'(bus.ram_in),   32'd0);
        @(negedge clk);
        check_output("rstacc_no_rvalid", 32'(bus.rvalid0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_access(0, 1'b0, 9'd7, 16'h0000, gl, rl, rd, ld);
        check_output("rd7_unchanged", 32'(rd), 32'h0777);
        check_output("rd7_gnt_latency", 32'(gl), 32'd1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
